// File: rtl/approx_mult_pkg.sv
// Shared types and default limits for the approximate multiplier controller.
package approx_mult_pkg;

  localparam int unsigned LSHIFT_MAX_DEF = 15;
  localparam int unsigned RSHIFT_MAX_DEF = 31;

  typedef enum logic [6:0] {
    ST_IDLE   = 7'b000_0001,
    ST_LOAD   = 7'b000_0010,
    ST_LOAD_L = 7'b000_0100,
    ST_LSHIFT = 7'b000_1000,
    ST_LOAD_R = 7'b001_0000,
    ST_RSHIFT = 7'b010_0000,
    ST_DONE   = 7'b100_0000
  } ctrl_state_e;

endpackage

// File: rtl/approx_mult_controller.sv
// One-hot sequencing FSM for the approximate multiplier datapath.
// Define APPROX_CTRL_WDOG_EN to bound the shift phases with a watchdog that raises err.
module approx_mult_controller
  import approx_mult_pkg::*;
#(
  parameter int unsigned LSHIFT_MAX = LSHIFT_MAX_DEF,
  parameter int unsigned RSHIFT_MAX = RSHIFT_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  input  logic a_shifting,
  input  logic b_shifting,
  input  logic r_shifting,
  output logic ld,
  output logic ld_l_shift,
  output logic ld_r_shift,
  output logic l_count_en,
  output logic r_count_en,
  output logic l_shift_allowed,
  output logic r_shift_allowed,
  output logic cnt_clr,
  output logic err
);

  if (LSHIFT_MAX < 1 || LSHIFT_MAX > 31 || RSHIFT_MAX < 1 || RSHIFT_MAX > 31) begin : g_bad_limits
    $error("approx_mult_controller: LSHIFT_MAX and RSHIFT_MAX must be in 1..31");
  end

  ctrl_state_e state_q, state_d;
  logic        l_busy;
  logic        l_trip;
  logic        r_trip;
  logic        idle_rdy;

  assign l_busy = a_shifting | b_shifting;
  // The async reset parks the FSM in IDLE, so readiness is masked until reset releases.
  assign in_ready = idle_rdy & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    idle_rdy        = 1'b0;
    ld              = 1'b0;
    cnt_clr         = 1'b0;
    ld_l_shift      = 1'b0;
    ld_r_shift      = 1'b0;
    l_shift_allowed = 1'b0;
    l_count_en      = 1'b0;
    r_shift_allowed = 1'b0;
    r_count_en      = 1'b0;
    out_valid       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        idle_rdy = 1'b1;
        if (in_valid) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ld      = 1'b1;
        cnt_clr = 1'b1;
        state_d = ST_LOAD_L;
      end
      ST_LOAD_L: begin
        ld_l_shift = 1'b1;
        state_d    = ST_LSHIFT;
      end
      ST_LSHIFT: begin
        if (l_busy) begin
          l_shift_allowed = 1'b1;
          l_count_en      = 1'b1;
          if (l_trip) state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD_R;
        end
      end
      ST_LOAD_R: begin
        ld_r_shift = 1'b1;
        // With no right shift pending RSHIFT is bypassed, giving the 5-cycle zero-shift path.
        state_d    = r_shifting ? ST_RSHIFT : ST_DONE;
      end
      ST_RSHIFT: begin
        if (r_shifting) begin
          r_shift_allowed = 1'b1;
          r_count_en      = 1'b1;
          if (r_trip) state_d = ST_DONE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef APPROX_CTRL_WDOG_EN
  localparam int unsigned PHASE_W = 5;
  localparam logic [PHASE_W-1:0] L_LAST = PHASE_W'(LSHIFT_MAX - 1);
  localparam logic [PHASE_W-1:0] R_LAST = PHASE_W'(RSHIFT_MAX - 1);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               err_q, err_d;

  // phase_q counts cycles already spent in the current shift phase.
  assign l_trip = (phase_q == L_LAST);
  assign r_trip = (phase_q == R_LAST);
  assign err    = err_q;

  always_comb begin
    phase_d = phase_q;
    err_d   = err_q;
    if (state_q == ST_LOAD_L || state_q == ST_LOAD_R) begin
      phase_d = '0;
    end else if (state_q == ST_LSHIFT || state_q == ST_RSHIFT) begin
      phase_d = phase_q + PHASE_W'(1);
    end
    if ((state_q == ST_LSHIFT && l_busy && l_trip) ||
        (state_q == ST_RSHIFT && r_shifting && r_trip)) begin
      err_d = 1'b1;
    end else if (state_q == ST_DONE && out_ready) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
      err_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      err_q   <= err_d;
    end
  end
`else
  assign l_trip = 1'b0;
  assign r_trip = 1'b0;
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_approx_mult_controller.sv
// Directed and randomized checks of approx_mult_controller against a cycle-timeline model.
module tb_approx_mult_controller;

  localparam int LMAX = 15;
  localparam int RMAX = 31;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic a_shifting, b_shifting, r_shifting;
  logic ld, ld_l_shift, ld_r_shift, l_count_en, r_count_en;
  logic l_shift_allowed, r_shift_allowed, cnt_clr, err;
  logic [10:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  approx_mult_controller #(.LSHIFT_MAX(LMAX), .RSHIFT_MAX(RMAX)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_shifting(a_shifting), .b_shifting(b_shifting), .r_shifting(r_shifting),
    .ld(ld), .ld_l_shift(ld_l_shift), .ld_r_shift(ld_r_shift),
    .l_count_en(l_count_en), .r_count_en(r_count_en),
    .l_shift_allowed(l_shift_allowed), .r_shift_allowed(r_shift_allowed),
    .cnt_clr(cnt_clr), .err(err)
  );

  // {in_ready, ld, cnt_clr, ld_l, l_allow, l_cnt, ld_r, r_allow, r_cnt, out_valid, err}
  assign obs = {in_ready, ld, cnt_clr, ld_l_shift, l_shift_allowed, l_count_en,
                ld_r_shift, r_shift_allowed, r_count_en, out_valid, err};

  localparam logic [10:0] IDLE_VEC = 11'b100_0000_0000;

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  // Timeline model: cycle 0 is the accepting IDLE cycle; L = longer left-shift run,
  // rr = cycles r_shifting is high starting in LOAD_R; result appears at 5+L+rr.
  function automatic logic [10:0] exp_vec(input int c, input int la, input int lb, input int rr);
    int   L;
    logic l_en, r_en, ov;
    L    = (la > lb) ? la : lb;
    l_en = (c >= 3) && (c < 3 + L);
    r_en = (c >= 5 + L) && (c < 4 + L + rr);
    ov   = (c >= 5 + L + rr);
    return {c == 0, c == 1, c == 1, c == 2, l_en, l_en, c == 4 + L, r_en, r_en, ov, 1'b0};
  endfunction

  // Inputs the FSM must honour follow the timeline; everything else is random noise.
  task automatic drive(input int c, input int la, input int lb, input int rr, input int bp,
                       input bit hold);
    int L, D;
    L = (la > lb) ? la : lb;
    D = 5 + L + rr;
    in_valid   = (c == 0 || hold) ? 1'b1 : 1'($urandom);
    a_shifting = (c >= 3 && c <= 3 + L) ? (c < 3 + la) : 1'($urandom);
    b_shifting = (c >= 3 && c <= 3 + L) ? (c < 3 + lb) : 1'($urandom);
    r_shifting = (c >= 4 + L && c <= 4 + L + rr) ? (c < 4 + L + rr) : 1'($urandom);
    out_ready  = (c >= D) ? (c >= D + bp) : 1'($urandom);
  endtask

  task automatic run_op(input string name, input int la, input int lb, input int rr,
                        input int bp, input bit hold);
    int last;
    last = 5 + ((la > lb) ? la : lb) + rr + bp;
    for (int c = 0; c <= last; c++) begin
      drive(c, la, lb, rr, bp, hold);
      @(negedge clk);
      check($sformatf("%s c%0d", name, c), obs, exp_vec(c, la, lb, rr));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_wdog(input string name, input bit right);
    int lim, d;
    logic l_en, r_en;
    lim = right ? RMAX : LMAX;
    d   = (right ? 5 : 3) + lim;
    for (int c = 0; c <= d + 1; c++) begin
      in_valid   = (c == 0);
      a_shifting = !right && c >= 3;
      b_shifting = 1'b0;
      r_shifting = right && c >= 4;
      out_ready  = (c == d + 1);
      @(negedge clk);
      l_en = !right && c >= 3 && c < d;
      r_en = right && c >= 5 && c < d;
      check($sformatf("%s c%0d", name, c), obs,
            {c == 0, c == 1, c == 1, c == 2, l_en, l_en, right && c == 4, r_en, r_en,
             c >= d, c >= d});
      @(posedge clk); #1;
    end
    in_valid = 1'b0; a_shifting = 1'b0; r_shifting = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check({name, " err_cleared"}, obs, IDLE_VEC);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int la, lb, rr, bp;
    bit hold;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a_shifting = 1'b1; b_shifting = 1'b1; r_shifting = 1'b1;
    #1 rst = 1'b0;
    #1 check("reset_async", obs, 11'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_held", obs, 11'b0);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    a_shifting = 1'b0; b_shifting = 1'b0; r_shifting = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("idle_after_release", obs, IDLE_VEC);
    @(posedge clk); #1;

    run_op("zero_shift", 0, 0, 0, 0, 1'b0);
    run_op("unequal_left", 3, 5, 0, 0, 1'b0);
    run_op("backpressure", 0, 0, 14, 4, 1'b0);
    run_op("busy_a", 2, 1, 3, 0, 1'b1);
    run_op("busy_b", 0, 4, 2, 1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      la   = $urandom_range(0, 10);
      lb   = $urandom_range(0, 10);
      rr   = $urandom_range(0, 12);
      bp   = $urandom_range(0, 3);
      hold = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), la, lb, rr, bp, hold);
    end

    // Reset during the second RSHIFT cycle (la=1 puts RSHIFT at cycles 6..).
    for (int c = 0; c <= 6; c++) begin
      drive(c, 1, 0, 5, 0, 1'b0);
      @(negedge clk);
      check($sformatf("midrst c%0d", c), obs, exp_vec(c, 1, 0, 5));
      @(posedge clk); #1;
    end
    drive(7, 1, 0, 5, 0, 1'b0);
    #1 check("midrst c7", obs, exp_vec(7, 1, 0, 5));
    rst = 1'b0;
    #1 check("midrst_async", obs, 11'b0);
    @(negedge clk);
    check("midrst_held", obs, 11'b0);
    @(posedge clk); #1;
    check("midrst_after_edge", obs, 11'b0);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("midrst_idle", obs, IDLE_VEC);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_no_result", obs, IDLE_VEC);
    @(posedge clk); #1;
    run_op("after_reset", 1, 2, 2, 1, 1'b0);

`ifdef APPROX_CTRL_WDOG_EN
    run_wdog("wdog_left", 1'b0);
    run_wdog("wdog_right", 1'b1);
`else
    run_op("unbounded_left", 40, 0, 0, 0, 1'b0);
    run_op("unbounded_right", 0, 0, 45, 0, 1'b0);
`endif
    run_op("final", 2, 2, 1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/approx_mult_controller.md
APPROX_MULT_CONTROLLER -- requirements
Module: approx_mult_controller

Interface
REQ-001 Parameter LSHIFT_MAX, default 15, is the watchdog limit in cycles for the left-normalize phase.
REQ-002 Parameter RSHIFT_MAX, default 31, is the watchdog limit in cycles for the right-denormalize phase.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  requester has operands A/B stable on the datapath inputs.
REQ-006 in_ready  output  1  controller accepts operands this cycle.
REQ-007 out_valid  output  1  output_result of the datapath is final.
REQ-008 out_ready  input  1  consumer takes the result.
REQ-009 a_shifting, b_shifting, r_shifting  input  1 each  datapath comparator status.
REQ-010 ld, ld_l_shift, ld_r_shift  output  1 each  datapath load strobes.
REQ-011 l_count_en, r_count_en, l_shift_allowed, r_shift_allowed  output  1 each  datapath counter and shift enables.
REQ-012 cnt_clr  output  1  synchronous clear for the datapath shift counters.
REQ-013 err  output  1  watchdog abort flag.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, LOAD_L, LSHIFT, LOAD_R, RSHIFT, DONE, encoded one-hot.
REQ-015 State behaviour, one row per state:
- IDLE: in_ready=1; in_valid=1 -> LOAD.
- LOAD: ld=1, cnt_clr=1 -> LOAD_L.
- LOAD_L: ld_l_shift=1 -> LSHIFT.
- LSHIFT: l_shift_allowed=1 and l_count_en=1 while (a_shifting|b_shifting); when both are 0 -> LOAD_R with enables deasserted that cycle.
- LOAD_R: ld_r_shift=1 -> RSHIFT.
- RSHIFT: r_shift_allowed=1 and r_count_en=1 while r_shifting; r_shifting=0 -> DONE.
- DONE: out_valid=1; out_ready=1 -> IDLE.
REQ-016 All FSM outputs SHALL be decoded from the state register plus the listed status inputs, with no other combinational input paths.
REQ-017 Minimum latency from in_valid acceptance to out_valid SHALL be 5 cycles (zero shifts), plus 1 cycle per left-shift cycle and 1 cycle per right-shift cycle.
REQ-018 out_valid SHALL remain high until out_ready is sampled high.
REQ-019 Back-to-back operation: DONE with out_ready=1 SHALL go to IDLE, and a new in_valid SHALL be accepted there one cycle later.
REQ-020 in_valid asserted outside IDLE SHALL be ignored, with in_ready=0.
REQ-021 An internal phase counter (5 bits) SHALL clear on entry to LSHIFT and to RSHIFT and increment each cycle spent in that state.

Reset
REQ-022 Asserting rst (low) at any time SHALL force IDLE and clear the phase counter and err immediately.
REQ-023 While rst is asserted, all outputs SHALL be 0 except in_ready, which SHALL be 0 during reset and 1 in the first cycle of IDLE after release.
REQ-024 Reset in the middle of an operation SHALL abandon that operation without producing out_valid.

Configuration
REQ-025 With APPROX_CTRL_WDOG_EN defined, the phase counter SHALL reaching LSHIFT_MAX in LSHIFT, or RSHIFT_MAX in RSHIFT, force DONE with err=1.
REQ-026 With APPROX_CTRL_WDOG_EN defined, err SHALL clear on the DONE->IDLE transition.
REQ-027 Without APPROX_CTRL_WDOG_EN, err SHALL be tied to 0, the phase counter SHALL be omitted, and the phases SHALL be unbounded.

Structure
REQ-028 The state enumeration and the LSHIFT_MAX/RSHIFT_MAX defaults SHALL live in the shared approx_mult_pkg package.
REQ-029 The FSM SHALL be a single module with no sub-modules; the watchdog counter SHALL be inline.

Verification
REQ-030 Zero shifts: in_valid=1 with a/b/r_shifting=0 -> ld, ld_l_shift, ld_r_shift pulse in cycles 1, 2, 4; out_valid in cycle 5.
REQ-031 Unequal left shifts: a_shifting high 3 cycles and b_shifting high 5 cycles -> l_count_en high exactly 5 cycles; out_valid in cycle 10.
REQ-032 Output backpressure: r_shifting high 14 cycles, then out_ready held 0 for 4 cycles -> out_valid stays high 4 cycles and drops one cycle after out_ready=1.
REQ-033 Mid-operation reset: rst low in cycle 2 of RSHIFT -> immediate IDLE, all strobes 0, no out_valid; the next operation completes normally.
REQ-034 Watchdog (macro on, LSHIFT_MAX=15): a_shifting stuck at 1 -> DONE after 15 LSHIFT cycles with err=1; err=0 after out_ready.
REQ-035 Busy input: in_valid held high throughout an operation -> only one ld pulse per operation; the next operation is accepted in IDLE.
